// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, in-order request tracking and
// a small queue of {pc, instr} entries feeding decode, with redirect flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_reg;
  logic [PW-1:0] alloc_ptr_reg, fill_ptr_reg, head_ptr_reg;
  logic [CW-1:0] count_reg;     // allocated, not yet popped
  logic [CW-1:0] inflight_reg;  // allocated, response not yet written
  logic [CW-1:0] drop_cnt_reg;  // responses still owed for flushed requests

  logic [31:0]      pc_arr    [DEPTH];
  logic [31:0]      instr_arr [DEPTH];
  logic [DEPTH-1:0] filled_vec;

  logic [CW:0] occupancy;
  logic        req_fire, resp_fill, resp_drop, pop;

  assign occupancy      = {1'b0, count_reg} + {1'b0, drop_cnt_reg};
  assign imem_req_valid = reset_n && !redirect && (occupancy < DEPTH_V);
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_drop      = imem_resp_valid && (drop_cnt_reg != '0);
  assign resp_fill      = imem_resp_valid && (drop_cnt_reg == '0);

  // An unfilled head blocks everything behind it, keeping program order.
  assign if_valid = !redirect && filled_vec[head_ptr_reg] && (count_reg != '0);
  assign if_pc    = pc_arr[head_ptr_reg];
  assign if_instr = instr_arr[head_ptr_reg];
  assign pop      = if_valid && if_ready;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] pc_reg;
      logic [31:0] instr_reg;
      logic        filled_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pc_reg     <= '0;
          instr_reg  <= '0;
          filled_reg <= 1'b0;
        end else if (redirect) begin
          filled_reg <= 1'b0;
        end else begin
          if (req_fire && alloc_ptr_reg == PW'(gi)) begin
            pc_reg     <= fetch_pc_reg;
            filled_reg <= 1'b0;
          end
          if (resp_fill && fill_ptr_reg == PW'(gi)) begin
            instr_reg  <= imem_resp_data;
            filled_reg <= 1'b1;
          end
          if (pop && head_ptr_reg == PW'(gi)) begin
            filled_reg <= 1'b0;
          end
        end
      end

      assign pc_arr[gi]     = pc_reg;
      assign instr_arr[gi]  = instr_reg;
      assign filled_vec[gi] = filled_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_reg  <= RESET_PC;
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      head_ptr_reg  <= '0;
      count_reg     <= '0;
      inflight_reg  <= '0;
      drop_cnt_reg  <= '0;
    end else if (redirect) begin
      fetch_pc_reg  <= {redirect_pc[31:2], 2'b00};
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      head_ptr_reg  <= '0;
      count_reg     <= '0;
      inflight_reg  <= '0;
      // A response arriving now retires one owed word, whether it was already
      // marked for dropping or belonged to an entry being flushed.
      drop_cnt_reg  <= drop_cnt_reg + inflight_reg - CW'(imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc_reg <= fetch_pc_reg + 32'd4;
      alloc_ptr_reg <= alloc_ptr_reg + PW'(req_fire);
      fill_ptr_reg  <= fill_ptr_reg + PW'(resp_fill);
      head_ptr_reg  <= head_ptr_reg + PW'(pop);
      count_reg     <= count_reg + CW'(req_fire) - CW'(pop);
      inflight_reg  <= inflight_reg + CW'(req_fire) - CW'(resp_fill);
      drop_cnt_reg  <= drop_cnt_reg - CW'(resp_drop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a behavioural memory plus a
// program-order model of the instruction stream checked at every negedge.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk, reset_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hA5A5_F00D;
  endfunction

  // Memory: in-order, one response per accepted request, latency in [lat_min, lat_max].
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int lat_min = 1;
  int lat_max = 1;

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) mq.delete();
      else if (imem_req_valid && imem_req_ready)
        mq.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (!reset_n) mq.delete();
      else if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end
    end
  end

  // Reference model: expected program-order stream plus request bookkeeping.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  int          outstanding = 0;  // current-stream requests awaiting a word
  int          stale = 0;        // words still owed for flushed requests

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      exp_q.delete();
      model_pc    = RESET_PC;
      outstanding = 0;
      stale       = 0;
      check1("rst_req_valid", imem_req_valid, 1'b0);
      check1("rst_if_valid", if_valid, 1'b0);
      check32("rst_req_addr", imem_req_addr, RESET_PC);
      check32("rst_if_pc", if_pc, 32'h0);
      check32("rst_if_instr", if_instr, 32'h0);
    end else begin
      logic exp_req, exp_ifv;
      exp_req = !redirect && (exp_q.size() + stale < DEPTH);
      exp_ifv = !redirect && (exp_q.size() > outstanding);
      check1("req_valid", imem_req_valid, exp_req);
      check1("if_valid", if_valid, exp_ifv);
      if (exp_ifv && if_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        check32("if_pc", if_pc, e.pc);
        check32("if_instr", if_instr, e.instr);
      end
      if (exp_req && imem_req_ready) begin
        check32("req_addr", imem_req_addr, model_pc);
        exp_q.push_back('{model_pc, mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
        outstanding++;
      end
      if (imem_resp_valid) begin
        if (stale > 0) stale--;
        else outstanding--;
      end
      if (redirect) begin
        exp_q.delete();
        stale      += outstanding;
        outstanding = 0;
        model_pc    = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  task automatic do_reset(input logic rdy, input logic ifr, input int lmin, input int lmax);
    @(posedge clk);
    #2;
    reset_n  = 1'b0;
    redirect = 1'b0;
    #1;
    check1("async_clr_req_valid", imem_req_valid, 1'b0);
    check1("async_clr_if_valid", if_valid, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    imem_req_ready = rdy;
    if_ready       = ifr;
    lat_min        = lmin;
    lat_max        = lmax;
    #1;
    reset_n = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = target;
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  task automatic wait_first_pc(input string nm, input logic [31:0] exp);
    bit found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (if_valid) found = 1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: if_valid never rose, expected pc %h", nm, exp);
    end else begin
      check32(nm, if_pc, exp);
    end
  endtask

  initial begin
    reset_n        = 1'b1;
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);

    // 1: streaming with a 1-cycle memory
    do_reset(1'b1, 1'b1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("t1_req_valid", imem_req_valid, 1'b1);
      check32("t1_req_addr", imem_req_addr, 32'(4 * i));
      check1("t1_if_valid", if_valid, i >= 2);
      if (i >= 2) check32("t1_if_pc", if_pc, 32'(4 * (i - 2)));
    end

    // 2: back-pressure fills the queue
    do_reset(1'b1, 1'b0, 1, 1);
    begin
      int acc = 0;
      repeat (12) begin
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) acc++;
      end
      check32("t2_accepts", 32'(acc), 32'(DEPTH));
    end
    @(posedge clk);
    #1 if_ready = 1'b1;
    @(negedge clk);
    check1("t2_full_req_valid", imem_req_valid, 1'b0);
    check1("t2_head_valid", if_valid, 1'b1);
    @(negedge clk);
    check1("t2_resume_valid", imem_req_valid, 1'b1);
    check32("t2_resume_addr", imem_req_addr, 32'h10);

    // 3: redirect with two requests in flight, 3-cycle memory
    do_reset(1'b1, 1'b1, 3, 3);
    repeat (1) @(posedge clk);
    pulse_redirect(32'h103);
    @(negedge clk);
    check32("t3_req_addr", imem_req_addr, 32'h100);
    wait_first_pc("t3_first_pc", 32'h100);

    // 4: redirect coinciding with a response and a consumable head
    do_reset(1'b1, 1'b1, 1, 1);
    repeat (6) @(posedge clk);
    pulse_redirect(32'h400);
    wait_first_pc("t4_first_pc", 32'h400);

    // 5: back-to-back redirects with responses pending
    do_reset(1'b1, 1'b1, 4, 4);
    repeat (3) @(posedge clk);
    pulse_redirect(32'h200);
    pulse_redirect(32'h300);
    wait_first_pc("t5_first_pc", 32'h300);

    // 6: address wrap, then asynchronous reset mid-burst
    do_reset(1'b1, 1'b1, 1, 2);
    pulse_redirect(32'hFFFF_FFFC);
    @(negedge clk);
    check32("t6_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check32("t6_addr_wrap", imem_req_addr, 32'h0);
    repeat (2) @(negedge clk);
    do_reset(1'b1, 1'b1, 1, 4);
    @(negedge clk);
    check1("t6_restart_valid", imem_req_valid, 1'b1);
    check32("t6_restart_addr", imem_req_addr, RESET_PC);

    // Randomized traffic; the scoreboard checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      imem_req_ready = ($urandom_range(3, 0) != 0);
      if_ready       = ($urandom_range(2, 0) != 0);
      redirect       = ($urandom_range(19, 0) == 0);
      redirect_pc    = $urandom;
    end
    @(posedge clk);
    #1;
    redirect       = 1'b0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    repeat (30) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
